// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB-Lite encodings and capture record types
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic {
        CAP_IDLE,
        CAP_DATA
    } cap_state_e;

    // Width-independent part of a record; the address/data fields are
    // added by the user, which knows ADDR_W/DATA_W.
    typedef struct packed {
        logic       write;
        logic [2:0] size;
        logic       err;
        logic       seq;
    } xfer_meta_t;

    // NONSEQ and SEQ carry a real transfer; IDLE and BUSY never do.
    function automatic logic htrans_active(input logic [1:0] htrans);
        return htrans[1];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO with occupancy count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_fire;
    logic             pop_fire;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign level_o = level_q;

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign pop_fire  = pop_i && !empty_o;
    assign push_fire = push_i && (!full_o || pop_fire);

    // Head is forced to zero when empty so the outputs never expose stale storage.
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_fire) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_fire, pop_fire})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/ahb_transfer_capture.sv
// rtl/ahb_transfer_capture.sv - records completed AHB-Lite transfers into a drainable FIFO
module ahb_transfer_capture
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [ADDR_W-1:0]          haddr,
    input  logic [1:0]                 htrans,
    input  logic                       hwrite,
    input  logic [2:0]                 hsize,
    input  logic [DATA_W-1:0]          hwdata,
    input  logic [DATA_W-1:0]          hrdata,
    input  logic                       hready,
    input  logic                       hresp,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADDR_W-1:0]          out_addr,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_write,
    output logic [2:0]                 out_size,
    output logic                       out_err,
    output logic                       out_seq,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow,
    input  logic                       clr_overflow
);

    localparam int LVL_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        xfer_meta_t        meta;
    } xfer_rec_t;

    localparam int REC_W = $bits(xfer_rec_t);

    cap_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              pend_write_q, pend_write_d;
    logic [2:0]        pend_size_q, pend_size_d;
    logic              pend_seq_q, pend_seq_d;
    logic              overflow_q, overflow_d;

    logic              accept;
    logic              push;
    xfer_rec_t         push_rec;
    xfer_rec_t         head_rec;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              drop;

    assign accept = hready && htrans_active(htrans);

    always_comb begin
        state_d      = state_q;
        pend_addr_d  = pend_addr_q;
        pend_write_d = pend_write_q;
        pend_size_d  = pend_size_q;
        pend_seq_d   = pend_seq_q;
        push         = 1'b0;

        push_rec           = '0;
        push_rec.addr      = pend_addr_q;
        push_rec.data      = pend_write_q ? hwdata : hrdata;
        push_rec.meta.write = pend_write_q;
        push_rec.meta.size  = pend_size_q;
        push_rec.meta.err   = (hresp == HRESP_ERROR);
        push_rec.meta.seq   = pend_seq_q;

        case (state_q)
            CAP_IDLE: begin
                if (accept) begin
                    state_d = CAP_DATA;
                end
            end
            CAP_DATA: begin
                // hready low (including the first ERROR cycle) holds the data phase.
                if (hready) begin
                    push    = 1'b1;
                    state_d = accept ? CAP_DATA : CAP_IDLE;
                end
            end
            default: state_d = CAP_IDLE;
        endcase

        if (accept) begin
            pend_addr_d  = haddr;
            pend_write_d = hwrite;
            pend_size_d  = hsize;
            pend_seq_d   = htrans[0];
        end
    end

    assign pop  = !fifo_empty && out_ready;
    assign drop = push && fifo_full && !pop;

    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= CAP_IDLE;
            pend_addr_q  <= '0;
            pend_write_q <= 1'b0;
            pend_size_q  <= '0;
            pend_seq_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_addr_q  <= pend_addr_d;
            pend_write_q <= pend_write_d;
            pend_size_q  <= pend_size_d;
            pend_seq_q   <= pend_seq_d;
            overflow_q   <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push_i    (push),
        .wr_data_i (push_rec),
        .pop_i     (pop),
        .rd_data_o (head_rec),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (level)
    );

    assign out_valid = !fifo_empty;
    assign out_addr  = head_rec.addr;
    assign out_data  = head_rec.data;
    assign out_write = head_rec.meta.write;
    assign out_size  = head_rec.meta.size;
    assign out_err   = head_rec.meta.err;
    assign out_seq   = head_rec.meta.seq;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_ahb_transfer_capture.sv
// tb/tb_ahb_transfer_capture.sv - directed bench with a queue-based transfer model
module tb_ahb_transfer_capture;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rstn;
    logic [AW-1:0] haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [DW-1:0] hwdata;
    logic [DW-1:0] hrdata;
    logic          hready;
    logic          hresp;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          out_write;
    logic [2:0]    out_size;
    logic          out_err;
    logic          out_seq;
    logic [LW-1:0] level;
    logic          overflow;
    logic          clr_overflow;

    ahb_transfer_capture #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
        .hsize(hsize), .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
        .out_write(out_write), .out_size(out_size), .out_err(out_err), .out_seq(out_seq),
        .level(level), .overflow(overflow), .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          write;
        logic [2:0]    size;
        logic          err;
        logic          seq;
    } rec_t;

    rec_t mq[$];
    rec_t mpend;
    rec_t m_r;
    bit   mpend_v = 1'b0;
    bit   movf    = 1'b0;
    bit   m_pop;
    bit   m_drop;
    int   m_sz;

    int n_chk  = 0;
    int n_fail = 0;

    function automatic void cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Transaction-level model: one pending transfer, a record queue, a sticky flag.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mq.delete();
            mpend_v = 1'b0;
            movf    = 1'b0;
        end else begin
            m_sz   = mq.size();
            m_pop  = (m_sz > 0) && out_ready;
            m_drop = 1'b0;
            if (m_pop) void'(mq.pop_front());
            if (mpend_v && hready) begin
                m_r      = mpend;
                m_r.data = mpend.write ? hwdata : hrdata;
                m_r.err  = hresp;
                if (m_sz < DEPTH || m_pop) mq.push_back(m_r);
                else m_drop = 1'b1;
            end
            if (m_drop) movf = 1'b1;
            else if (clr_overflow) movf = 1'b0;
            if (hready) begin
                mpend_v = htrans[1];
                if (htrans[1]) begin
                    mpend.addr  = haddr;
                    mpend.write = hwrite;
                    mpend.size  = hsize;
                    mpend.seq   = htrans[0];
                    mpend.data  = '0;
                    mpend.err   = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        cmp("out_valid", 64'(out_valid), 64'(mq.size() > 0));
        cmp("level", 64'(level), 64'(mq.size()));
        cmp("overflow", 64'(overflow), 64'(movf));
        if (mq.size() > 0) begin
            cmp("out_addr", 64'(out_addr), 64'(mq[0].addr));
            cmp("out_data", 64'(out_data), 64'(mq[0].data));
            cmp("out_write", 64'(out_write), 64'(mq[0].write));
            cmp("out_size", 64'(out_size), 64'(mq[0].size));
            cmp("out_err", 64'(out_err), 64'(mq[0].err));
            cmp("out_seq", 64'(out_seq), 64'(mq[0].seq));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'b010;
        hwdata = '0; hrdata = '0; hready = 1'b1; hresp = 1'b0;
        out_ready = 1'b0; clr_overflow = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp("rst_valid", 64'(out_valid), 64'd0);
        cmp("rst_level", 64'(level), 64'd0);
        cmp("rst_ovf", 64'(overflow), 64'd0);
        cmp("rst_addr", 64'(out_addr), 64'd0);
        rstn = 1'b1;
        step();

        // single read, no wait
        htrans = 2'b10; haddr = 32'h100; hwrite = 1'b0; step();
        htrans = 2'b00; hrdata = 32'hDEADBEEF; step();
        @(negedge clk);
        cmp("t1_valid", 64'(out_valid), 64'd1);
        cmp("t1_addr", 64'(out_addr), 64'h100);
        cmp("t1_data", 64'(out_data), 64'hDEADBEEF);
        cmp("t1_write", 64'(out_write), 64'd0);
        cmp("t1_err", 64'(out_err), 64'd0);
        cmp("t1_level", 64'(level), 64'd1);
        out_ready = 1'b1; step(); out_ready = 1'b0;

        // write with two wait states
        htrans = 2'b10; haddr = 32'h204; hwrite = 1'b1; step();
        htrans = 2'b00; hready = 1'b0; step();
        @(negedge clk);
        cmp("t2_wait_level", 64'(level), 64'd0);
        step();
        @(negedge clk);
        cmp("t2_wait2_level", 64'(level), 64'd0);
        hready = 1'b1; hwdata = 32'h12345678; step();
        @(negedge clk);
        cmp("t2_level", 64'(level), 64'd1);
        cmp("t2_addr", 64'(out_addr), 64'h204);
        cmp("t2_data", 64'(out_data), 64'h12345678);
        cmp("t2_write", 64'(out_write), 64'd1);
        out_ready = 1'b1; step(); out_ready = 1'b0; hwrite = 1'b0;

        // pipelined burst
        htrans = 2'b10; haddr = 32'h0; step();
        for (int k = 1; k < 4; k++) begin
            htrans = 2'b11; haddr = 32'(4 * k); hrdata = 32'(k); step();
        end
        htrans = 2'b00; hrdata = 32'd4; step();
        @(negedge clk);
        cmp("t3_level", 64'(level), 64'd4);
        for (int i = 0; i < 4; i++) begin
            cmp("t3_data", 64'(out_data), 64'(i + 1));
            cmp("t3_seq", 64'(out_seq), 64'(i != 0));
            cmp("t3_addr", 64'(out_addr), 64'(4 * i));
            out_ready = 1'b1; step();
            @(negedge clk);
        end
        out_ready = 1'b0;

        // error response after one ERROR wait cycle
        htrans = 2'b10; haddr = 32'h300; hsize = 3'b001; step();
        htrans = 2'b00; hready = 1'b0; hresp = 1'b1; hrdata = 32'hBAD; step();
        hready = 1'b1; step();
        hresp = 1'b0;
        @(negedge clk);
        cmp("t4_err", 64'(out_err), 64'd1);
        cmp("t4_addr", 64'(out_addr), 64'h300);
        cmp("t4_size", 64'(out_size), 64'd1);
        out_ready = 1'b1; step(); out_ready = 1'b0; hsize = 3'b010;

        // overflow with five pipelined reads
        htrans = 2'b10; haddr = 32'h10; step();
        for (int k = 1; k < 5; k++) begin
            htrans = 2'b11; haddr = 32'(32'h10 + 4 * k); hrdata = 32'(k); step();
        end
        htrans = 2'b00; hrdata = 32'd5; step();
        @(negedge clk);
        cmp("t5_level", 64'(level), 64'd4);
        cmp("t5_ovf", 64'(overflow), 64'd1);
        cmp("t5_head", 64'(out_addr), 64'h10);
        htrans = 2'b10; haddr = 32'h40; step();
        htrans = 2'b00; hrdata = 32'h55; out_ready = 1'b1; step();
        out_ready = 1'b0;
        @(negedge clk);
        cmp("t5_pp_level", 64'(level), 64'd4);
        cmp("t5_pp_head", 64'(out_addr), 64'h14);
        cmp("t5_pp_ovf", 64'(overflow), 64'd1);
        clr_overflow = 1'b1; step(); clr_overflow = 1'b0;
        @(negedge clk);
        cmp("t5_clr", 64'(overflow), 64'd0);
        out_ready = 1'b1; repeat (4) step(); out_ready = 1'b0;

        // reset in the middle of a data phase
        htrans = 2'b10; haddr = 32'h600; step();
        htrans = 2'b00; hrdata = 32'h66; step();
        htrans = 2'b10; haddr = 32'h500; step();
        htrans = 2'b00; hready = 1'b0; step();
        rstn = 1'b0;
        @(negedge clk);
        cmp("t6_valid", 64'(out_valid), 64'd0);
        cmp("t6_level", 64'(level), 64'd0);
        cmp("t6_ovf", 64'(overflow), 64'd0);
        step();
        rstn = 1'b1; hready = 1'b1; hrdata = 32'h77;
        repeat (3) step();
        @(negedge clk);
        cmp("t6_post_level", 64'(level), 64'd0);
        cmp("t6_post_valid", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
